// File: rtl/ethernet_hexdump.sv
// Pops bytes from the Ethernet receive FIFO and writes them to the UART transmit FIFO
// as uppercase hex text: "XX " per byte, CR/LF after a full line or an idle gap.
module ethernet_hexdump #(
  parameter int BYTES_PER_LINE = 16,
  parameter int IDLE_CYCLES    = 5000,
  parameter int TW             = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_rd,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_SEP,
    S_CR,
    S_LF
  } state_t;

  localparam logic [7:0]    LAST_COL = 8'(BYTES_PER_LINE - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_CYCLES - 1);

  state_t        state;
  logic [7:0]    byte_q;
  logic [7:0]    line_cnt;
  logic [TW-1:0] timer;
  logic          emit;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Handshake: rx_rd pops the FIFO head in the same cycle the byte is latched;
  // tx_wr writes tx_data whenever a character is pending and the UART FIFO has room.
  always_comb begin
    emit    = (state != S_IDLE);
    tx_wr   = emit & ~tx_full;
    rx_rd   = (state == S_IDLE) & ~rx_empty & ~reset;
    tx_data = 8'h00;
    case (state)
      S_HI:    tx_data = hex_char(byte_q[7:4]);
      S_LO:    tx_data = hex_char(byte_q[3:0]);
      S_SEP:   tx_data = 8'h20;
      S_CR:    tx_data = 8'h0D;
      S_LF:    tx_data = 8'h0A;
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_q   <= 8'h00;
      line_cnt <= 8'h00;
      timer    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_empty) begin
            byte_q <= rx_data;
            timer  <= '0;
            state  <= S_HI;
          end else if (line_cnt != 8'h00) begin
            // A partial line is open: close it after a long enough quiet period.
            if (timer == TIMER_MAX) begin
              timer <= '0;
              state <= S_CR;
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            timer <= '0;
          end
        end
        S_HI: if (tx_wr) state <= S_LO;
        S_LO: begin
          if (tx_wr) begin
            if (line_cnt == LAST_COL) begin
              state <= S_CR;
            end else begin
              line_cnt <= line_cnt + 8'h01;
              state    <= S_SEP;
            end
          end
        end
        S_SEP: if (tx_wr) state <= S_IDLE;
        S_CR:  if (tx_wr) state <= S_LF;
        S_LF: begin
          if (tx_wr) begin
            line_cnt <= 8'h00;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_hexdump.sv
// Directed bench for ethernet_hexdump: a text-stream model builds the expected
// character queue, and a negedge monitor checks every UART write against it.
module tb_ethernet_hexdump;

  localparam int BPL  = 4;
  localparam int IDLE = 20;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rd;
  logic       tx_full = 1'b0;
  logic       tx_wr;
  logic [7:0] tx_data;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] wr_log[$];
  int         gap_log[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         rd_count = 0;
  int         idle_run = 0;
  int         m_cnt = 0;
  logic       rd_prev = 1'b0;
  string      hexs = "0123456789ABCDEF";

  ethernet_hexdump #(
    .BYTES_PER_LINE(BPL),
    .IDLE_CYCLES(IDLE),
    .TW(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_empty(rx_empty),
    .rx_data(rx_data),
    .rx_rd(rx_rd),
    .tx_full(tx_full),
    .tx_wr(tx_wr),
    .tx_data(tx_data)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // Receive FIFO model: pops on rx_rd, presents garbage data while empty
  always begin
    logic pend;
    @(negedge clk);
    pend = rx_rd && !reset;
    @(posedge clk);
    #2;
    if (pend && rx_q.size() != 0) void'(rx_q.pop_front());
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'($urandom_range(0, 255)) : rx_q[0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected text for a byte and for an idle gap
  function automatic void model_byte(input logic [7:0] b);
    exp_q.push_back(8'(hexs[int'(b[7:4])]));
    exp_q.push_back(8'(hexs[int'(b[3:0])]));
    if (m_cnt == BPL - 1) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_cnt = 0;
    end else begin
      exp_q.push_back(8'h20);
      m_cnt++;
    end
  endfunction

  function automatic void model_timeout();
    if (m_cnt != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_cnt = 0;
    end
  endfunction

  // Scoreboard / compare process
  always @(negedge clk) begin
    if (reset) begin
      rd_prev = 1'b0;
    end else begin
      if (rx_rd) begin
        rd_count++;
        check("rd_not_back_to_back", 32'(rd_prev), 32'd0);
      end
      rd_prev = rx_rd;
      if (tx_wr) begin
        wr_log.push_back(tx_data);
        gap_log.push_back(idle_run);
        idle_run = 0;
        check("wr_while_full", 32'(tx_full), 32'd0);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_wr: got %0h expected no write at %0t", tx_data, $time);
        end else begin
          check("char", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end else begin
        idle_run++;
      end
    end
  end

  // Driver tasks
  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_data(input string name, input logic [7:0] c, input int budget);
    int n = 0;
    @(negedge clk);
    while (tx_data != c && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(tx_data), 32'(c));
  endtask

  task automatic check_log(input string name, input byte_q_t exp);
    check({name, "_len"}, 32'(wr_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
      check(name, 32'(wr_log[i]), 32'(exp[i]));
  endtask

  task automatic clear_logs();
    wr_log.delete();
    gap_log.delete();
    rd_count = 0;
  endtask

  initial begin
    byte_q_t lit;

    // Reset state
    cycles(3);
    check("reset_tx_wr", 32'(tx_wr), 32'd0);
    check("reset_rx_rd", 32'(rx_rd), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;

    // Empty FIFO for 200 cycles
    clear_logs();
    cycles(200);
    check("idle_no_rd", 32'(rd_count), 32'd0);
    check("idle_no_wr", 32'(wr_log.size()), 32'd0);

    // Single byte 0x3A, then timeout CR/LF after 20 empty cycles
    clear_logs();
    push(8'h3A);
    model_byte(8'h3A);
    wait_drain("t1_drain", 40);
    model_timeout();
    wait_drain("t1_timeout_drain", 60);
    lit = '{8'h33, 8'h41, 8'h20, 8'h0D, 8'h0A};
    check_log("t1_log", lit);
    if (gap_log.size() > 3) check("t1_idle_gap", 32'(gap_log[3]), 32'd20);
    else check("t1_idle_gap_missing", 32'(gap_log.size()), 32'd4);
    check("t1_rd_pulses", 32'(rd_count), 32'd1);
    cycles(60);
    check("t1_nothing_more", 32'(wr_log.size()), 32'd5);

    // Full line: no trailing space, immediate CR/LF, no later timeout
    clear_logs();
    push(8'h00); push(8'hFF); push(8'h9C); push(8'hA5);
    model_byte(8'h00); model_byte(8'hFF); model_byte(8'h9C); model_byte(8'hA5);
    wait_drain("t2_drain", 200);
    lit = '{8'h30, 8'h30, 8'h20, 8'h46, 8'h46, 8'h20, 8'h39, 8'h43, 8'h20,
            8'h41, 8'h35, 8'h0D, 8'h0A};
    check_log("t2_log", lit);
    cycles(60);
    check("t2_no_timeout", 32'(wr_log.size()), 32'd13);

    // Back-pressure during LO of 0x7E
    clear_logs();
    push(8'h7E);
    model_byte(8'h7E);
    wait_data("t3_hi_seen", 8'h37, 40);
    @(posedge clk);
    #1 tx_full = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t3_full_no_wr", 32'(tx_wr), 32'd0);
      check("t3_full_data", 32'(tx_data), 32'h45);
    end
    @(posedge clk);
    #1 tx_full = 1'b0;
    wait_drain("t3_drain", 20);
    lit = '{8'h37, 8'h45, 8'h20};
    check_log("t3_log", lit);
    if (gap_log.size() > 1) check("t3_lo_gap", 32'(gap_log[1]), 32'd10);
    model_timeout();
    wait_drain("t3_timeout_drain", 60);

    // Second byte arrives exactly on the expiry cycle
    clear_logs();
    push(8'h12);
    model_byte(8'h12);
    wait_data("t4_sep_seen", 8'h20, 40);
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1;
    push(8'h34);
    model_byte(8'h34);
    @(negedge clk);
    check("t4_rd_at_expiry", 32'(rx_rd), 32'd1);
    wait_drain("t4_drain", 40);
    model_timeout();
    wait_drain("t4_timeout_drain", 60);
    lit = '{8'h31, 8'h32, 8'h20, 8'h33, 8'h34, 8'h20, 8'h0D, 8'h0A};
    check_log("t4_log", lit);
    if (gap_log.size() > 3) check("t4_gap", 32'(gap_log[3]), 32'd20);

    // Reset during HI of 0x5B
    clear_logs();
    tx_full = 1'b1;
    push(8'h5B);
    wait_data("t5_hi_seen", 8'h35, 40);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_tx_wr", 32'(tx_wr), 32'd0);
    check("t5_rst_rx_rd", 32'(rx_rd), 32'd0);
    check("t5_rst_tx_data", 32'(tx_data), 32'd0);
    exp_q.delete();
    m_cnt = 0;
    cycles(2);
    reset = 1'b0;
    tx_full = 1'b0;
    cycles(60);
    check("t5_no_wr_after_rst", 32'(wr_log.size()), 32'd0);
    push(8'h01);
    model_byte(8'h01);
    wait_drain("t5_drain", 40);
    lit = '{8'h30, 8'h31, 8'h20};
    check_log("t5_log", lit);
    model_timeout();
    wait_drain("t5_timeout_drain", 60);
    cycles(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
